// File: rtl/matrix_lsu_dispatcher_if.sv
// Issue-side, LSU-side and completion-side signals of the matrix LSU dispatcher.
// The dispatcher uses the slave modport. The issue/LSU/commit environment uses the master modport.
interface matrix_lsu_dispatcher_if #(
    parameter int N_REGS   = 8,
    parameter int ID_WIDTH = 4
);
    localparam int RW = $clog2(N_REGS);

    logic                instr_valid_i;
    logic                instr_ready_o;
    logic                instr_write_i;
    logic [31:0]         instr_addr_i;
    logic [31:0]         instr_stride_i;
    logic [RW-1:0]       instr_reg_i;
    logic [ID_WIDTH-1:0] instr_id_i;
    logic [31:0]         instr_ncols_i;
    logic [31:0]         instr_nrows_i;
    logic                flush_i;

    logic                start_o;
    logic                write_o;
    logic [31:0]         address_o;
    logic [31:0]         stride_o;
    logic [RW-1:0]       operand_reg_o;
    logic [ID_WIDTH-1:0] instr_id_o;
    logic [31:0]         n_bytes_cols_o;
    logic [31:0]         n_rows_o;

    logic                lsu_busy_i;
    logic                lsu_finished_i;
    logic [ID_WIDTH-1:0] lsu_finished_id_i;
    logic                lsu_finished_ack_o;

    logic                result_valid_o;
    logic [ID_WIDTH-1:0] result_id_o;
    logic                result_write_o;
    logic                result_ready_i;
    logic                id_err_o;

    modport slave (
        input  instr_valid_i, instr_write_i, instr_addr_i, instr_stride_i, instr_reg_i,
               instr_id_i, instr_ncols_i, instr_nrows_i, flush_i,
               lsu_busy_i, lsu_finished_i, lsu_finished_id_i, result_ready_i,
        output instr_ready_o, start_o, write_o, address_o, stride_o, operand_reg_o,
               instr_id_o, n_bytes_cols_o, n_rows_o, lsu_finished_ack_o,
               result_valid_o, result_id_o, result_write_o, id_err_o
    );

    modport master (
        output instr_valid_i, instr_write_i, instr_addr_i, instr_stride_i, instr_reg_i,
               instr_id_i, instr_ncols_i, instr_nrows_i, flush_i,
               lsu_busy_i, lsu_finished_i, lsu_finished_id_i, result_ready_i,
        input  instr_ready_o, start_o, write_o, address_o, stride_o, operand_reg_o,
               instr_id_o, n_bytes_cols_o, n_rows_o, lsu_finished_ack_o,
               result_valid_o, result_id_o, result_write_o, id_err_o
    );
endinterface

// File: rtl/matrix_lsu_dispatcher.sv
// In-order queue of matrix load/store instructions feeding the LSU one operation at a time.
// The head entry drives the LSU configuration from start through completion handshake.
module matrix_lsu_dispatcher #(
    parameter int DEPTH    = 2,
    parameter int N_REGS   = 8,
    parameter int ID_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    matrix_lsu_dispatcher_if.slave  bus
);
    localparam int RW = $clog2(N_REGS);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                write;
        logic [31:0]         addr;
        logic [31:0]         stride;
        logic [RW-1:0]       rg;
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         ncols;
        logic [31:0]         nrows;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        in_entry;
    state_t        state, state_nxt;
    logic [PW-1:0] wptr, rptr, used;
    logic [IW-1:0] widx, ridx;
    logic          empty, full, push, pop, start, res_valid, ack, id_err;

    assign used  = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (used == PW'(DEPTH));
    assign widx  = (DEPTH == 1) ? '0 : IW'(wptr);
    assign ridx  = (DEPTH == 1) ? '0 : IW'(rptr);
    assign head  = empty ? '0 : mem[ridx];

    // A flush swallows any push offered in the same cycle.
    assign push = bus.instr_valid_i & ~full & ~bus.flush_i;

    assign in_entry = '{write:  bus.instr_write_i,
                        addr:   bus.instr_addr_i,
                        stride: bus.instr_stride_i,
                        rg:     bus.instr_reg_i,
                        id:     bus.instr_id_i,
                        ncols:  bus.instr_ncols_i,
                        nrows:  bus.instr_nrows_i};

    always_ff @(posedge clk_i) begin
        if (push) mem[widx] <= in_entry;
    end

    // Once the head is issued it must survive a flush; only the entries behind it go.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (bus.flush_i) wptr <= (state == IDLE) ? rptr : rptr + PW'(1);
            else if (push)   wptr <= wptr + PW'(1);
            if (pop)         rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            id_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == WAIT && bus.lsu_finished_i && bus.lsu_finished_id_i != head.id)
                id_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        res_valid = 1'b0;
        ack       = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty && !bus.lsu_busy_i && !bus.flush_i) begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (bus.lsu_finished_i) state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (bus.result_ready_i) begin
                    ack       = 1'b1;
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.instr_ready_o      = ~full;
    assign bus.start_o            = start;
    assign bus.write_o            = head.write;
    assign bus.address_o          = head.addr;
    assign bus.stride_o           = head.stride;
    assign bus.operand_reg_o      = head.rg;
    assign bus.instr_id_o         = head.id;
    assign bus.n_bytes_cols_o     = head.ncols;
    assign bus.n_rows_o           = head.nrows;
    assign bus.lsu_finished_ack_o = ack;
    assign bus.result_valid_o     = res_valid;
    assign bus.result_id_o        = res_valid ? head.id : '0;
    assign bus.result_write_o     = res_valid & head.write;
    assign bus.id_err_o           = id_err;
endmodule

// File: tb/tb_matrix_lsu_dispatcher.sv
// Bench for matrix_lsu_dispatcher: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_matrix_lsu_dispatcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_lsu_dispatcher_if #(.N_REGS(8), .ID_WIDTH(4)) bus ();
    matrix_lsu_dispatcher #(.DEPTH(2), .N_REGS(8), .ID_WIDTH(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic v; logic w; logic [3:0] id; logic busy; logic fin; logic [3:0] fid;
        logic rdy; logic fl;
        logic e_rdy; logic e_st; logic e_rv; logic [3:0] e_rid; logic e_ack; logic e_err;
    } vec_t;
    vec_t tbl[$];

    typedef struct { logic w; logic [3:0] id; logic [31:0] a; } ment_t;
    ment_t mq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clr();
        bus.instr_valid_i = 0; bus.instr_write_i = 0; bus.instr_addr_i = 0;
        bus.instr_stride_i = 0; bus.instr_reg_i = 0; bus.instr_id_i = 0;
        bus.instr_ncols_i = 0; bus.instr_nrows_i = 0; bus.flush_i = 0;
        bus.lsu_busy_i = 0; bus.lsu_finished_i = 0; bus.lsu_finished_id_i = 0;
        bus.result_ready_i = 0;
    endtask

    task automatic offer(input logic w, input logic [3:0] id, input logic [31:0] a);
        bus.instr_valid_i = 1; bus.instr_write_i = w; bus.instr_id_i = id;
        bus.instr_addr_i = a; bus.instr_stride_i = 32'h10; bus.instr_reg_i = id[2:0];
        bus.instr_ncols_i = 32'd8; bus.instr_nrows_i = 32'd4;
    endtask

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic do_reset();
        clr();
        rst_n = 0;
        smp();
        chk("reset_state", 64'({bus.instr_ready_o, bus.start_o, bus.result_valid_o,
                                bus.lsu_finished_ack_o, bus.id_err_o, bus.result_id_o,
                                bus.instr_id_o, bus.address_o}),
            64'({5'b10000, 4'h0, 4'h0, 32'h0}));
        nxt();
        rst_n = 1;
    endtask

    initial begin
        int s;
        clr();

        // ---------------- A: single load, config and latency ----------------
        do_reset();
        offer(0, 4'd3, 32'h1000);
        bus.instr_reg_i = 3'd2; bus.instr_stride_i = 32'd16; bus.instr_nrows_i = 32'd4;
        smp(); chk("a_no_start_on_push", 64'(bus.start_o), 64'(0)); nxt();
        clr();
        smp();
        chk("a_start", 64'(bus.start_o), 64'(1));
        chk("a_cfg_main", 64'({bus.write_o, bus.operand_reg_o, bus.instr_id_o, bus.address_o}),
            64'({1'b0, 3'd2, 4'd3, 32'h1000}));
        chk("a_cfg_dims", 64'({bus.stride_o, bus.n_rows_o}), 64'({32'd16, 32'd4}));
        nxt();
        s = 0;
        repeat (8) begin smp(); s += int'(bus.start_o); nxt(); end
        chk("a_wait_no_start", 64'(s), 64'(0));
        bus.lsu_finished_i = 1; bus.lsu_finished_id_i = 4'd3;
        smp(); chk("a_wait_no_result", 64'(bus.result_valid_o), 64'(0)); nxt();
        bus.result_ready_i = 1;
        smp();
        chk("a_done_ack", 64'({bus.result_valid_o, bus.result_id_o, bus.lsu_finished_ack_o,
                               bus.result_write_o, bus.address_o}),
            64'({1'b1, 4'd3, 1'b1, 1'b0, 32'h1000}));
        nxt();
        clr();
        smp(); chk("a_after_pop", 64'({bus.result_valid_o, bus.instr_ready_o, bus.instr_id_o}),
                   64'({1'b0, 1'b1, 4'd0})); nxt();

        // ---------------- B: three back-to-back pushes, DEPTH=2 ----------------
        begin
            int nx, ns, na, wc;
            int pushc[3], startc[3], ackc[3];
            logic [3:0] got[$];
            bit infl, full2;
            logic [11:0] ord;
            nx = 0; ns = 0; na = 0; wc = 0; infl = 0; full2 = 0;
            for (int i = 0; i < 3; i++) begin pushc[i] = -1; startc[i] = -1; ackc[i] = 999; end
            do_reset();
            for (int cyc = 0; cyc < 40; cyc++) begin
                clr();
                bus.result_ready_i = 1;
                if (nx < 3) offer(0, 4'(nx + 1), 32'h2000 + 32'(nx));
                bus.lsu_finished_i = infl && wc == 0;
                bus.lsu_finished_id_i = 4'(ns);
                smp();
                if (nx == 2 && pushc[1] == cyc - 1) full2 = !bus.instr_ready_o;
                if (bus.lsu_finished_ack_o && na < 3) begin
                    got.push_back(bus.result_id_o); ackc[na] = cyc; na++; infl = 0;
                end
                if (bus.start_o && ns < 3) begin startc[ns] = cyc; ns++; infl = 1; wc = 2; end
                else if (wc > 0) wc--;
                if (nx < 3 && bus.instr_ready_o) begin pushc[nx] = cyc; nx++; end
                nxt();
            end
            chk("b_full_after_two", 64'(full2), 64'(1));
            ord = (got.size() == 3) ? {got[0], got[1], got[2]} : 12'h000;
            chk("b_order", 64'(ord), 64'(12'h123));
            chk("b_third_after_pop", 64'(pushc[2] > ackc[0]), 64'(1));
            chk("b_start_after_ack", 64'(startc[1] > ackc[0] && startc[2] > ackc[1]), 64'(1));
        end

        // ---------------- C/D: busy hold, then result backpressure ----------------
        do_reset();
        offer(1, 4'd6, 32'h3000); bus.lsu_busy_i = 1; smp(); s = int'(bus.start_o); nxt();
        offer(1, 4'd7, 32'h3100); bus.lsu_busy_i = 1; smp(); s += int'(bus.start_o); nxt();
        clr(); bus.lsu_busy_i = 1;
        repeat (4) begin smp(); s += int'(bus.start_o); nxt(); end
        chk("c_busy_no_start", 64'(s), 64'(0));
        bus.lsu_busy_i = 0;
        smp(); chk("c_start", 64'({bus.start_o, bus.instr_id_o, bus.write_o}),
                   64'({1'b1, 4'd6, 1'b1})); nxt();
        bus.lsu_finished_i = 1; bus.lsu_finished_id_i = 4'd6;
        smp(); nxt();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("d_hold", 64'({bus.result_valid_o, bus.lsu_finished_ack_o, bus.start_o,
                               bus.result_id_o, bus.address_o}),
                64'({3'b100, 4'd6, 32'h3000}));
            nxt();
        end
        bus.result_ready_i = 1;
        smp(); chk("d_ack", 64'({bus.result_valid_o, bus.lsu_finished_ack_o, bus.result_id_o,
                                 bus.result_write_o}), 64'({2'b11, 4'd6, 1'b1})); nxt();
        clr();
        smp(); chk("d_next_start", 64'({bus.start_o, bus.instr_id_o}), 64'({1'b1, 4'd7})); nxt();

        // ---------------- E: flush in WAIT with two entries ----------------
        do_reset();
        offer(0, 4'd8, 32'h4000); smp(); nxt();
        offer(0, 4'd9, 32'h4100); smp(); chk("e_start8", 64'(bus.start_o), 64'(1)); nxt();
        clr(); bus.flush_i = 1; smp(); nxt();
        clr(); bus.lsu_finished_i = 1; bus.lsu_finished_id_i = 4'd8; smp(); nxt();
        bus.result_ready_i = 1;
        smp(); chk("e_inflight_done", 64'({bus.result_valid_o, bus.lsu_finished_ack_o,
                                           bus.result_id_o}), 64'({2'b11, 4'd8})); nxt();
        clr();
        s = 0;
        repeat (6) begin smp(); s += int'(bus.start_o) + int'(bus.instr_id_o != 0); nxt(); end
        chk("e_flushed_never_starts", 64'(s), 64'(0));
        offer(0, 4'd10, 32'h5000); smp(); nxt();
        clr(); smp(); nxt();
        do_reset();

        // ---------------- T: vector table ----------------
        //          v  w  id    bsy fin fid   rdy fl | rdy st rv rid   ack err
        tbl.push_back('{1, 0, 4'd3, 0, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 1, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 1, 4'd3, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 1, 4'd3, 0, 0, 1, 0, 1, 4'd3, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 1, 4'd3, 1, 0, 1, 0, 1, 4'd3, 1, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 1, 4'd2, 1, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{1, 1, 4'd4, 0, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 1, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 1, 4'd5, 0, 0, 1, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{0, 0, 4'd0, 0, 1, 4'd5, 1, 0, 1, 0, 1, 4'd4, 1, 1});
        tbl.push_back('{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 1});
        tbl.push_back('{1, 0, 4'd9, 0, 0, 4'd0, 0, 1, 1, 0, 0, 4'd0, 0, 1});
        tbl.push_back('{0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 1});
        for (int i = 0; i < tbl.size(); i++) begin
            clr();
            if (tbl[i].v) offer(tbl[i].w, tbl[i].id, 32'h6000 + 32'(tbl[i].id));
            bus.lsu_busy_i = tbl[i].busy; bus.lsu_finished_i = tbl[i].fin;
            bus.lsu_finished_id_i = tbl[i].fid; bus.result_ready_i = tbl[i].rdy;
            bus.flush_i = tbl[i].fl;
            smp();
            chk($sformatf("vec%0d", i),
                64'({bus.instr_ready_o, bus.start_o, bus.result_valid_o, bus.result_id_o,
                     bus.lsu_finished_ack_o, bus.id_err_o}),
                64'({tbl[i].e_rdy, tbl[i].e_st, tbl[i].e_rv, tbl[i].e_rid,
                     tbl[i].e_ack, tbl[i].e_err}));
            nxt();
        end

        // ---------------- F: randomized run against reference model ----------------
        do_reset();
        begin
            bit infl, dn, merr, issued, popping, pushing, e_st, e_rv, e_rw, e_ack, fl;
            logic [3:0] e_rid, h_id;
            logic [31:0] h_a;
            ment_t ne;
            infl = 0; dn = 0; merr = 0;
            mq.delete();
            for (int c = 0; c < 400; c++) begin
                clr();
                if ($urandom_range(0, 1) == 1)
                    offer(1'($urandom), 4'($urandom), $urandom);
                bus.lsu_busy_i = ($urandom_range(0, 3) == 0);
                bus.lsu_finished_i = ($urandom_range(0, 2) == 0);
                bus.lsu_finished_id_i = (mq.size() > 0 && $urandom_range(0, 7) != 0)
                                        ? mq[0].id : 4'($urandom);
                bus.result_ready_i = ($urandom_range(0, 1) == 1);
                bus.flush_i = ($urandom_range(0, 19) == 0);
                fl = bus.flush_i;
                smp();
                h_id  = mq.size() > 0 ? mq[0].id : 4'd0;
                h_a   = mq.size() > 0 ? mq[0].a : 32'd0;
                e_st  = !infl && !dn && mq.size() > 0 && !bus.lsu_busy_i && !fl;
                e_rv  = dn;
                e_rid = dn ? h_id : 4'd0;
                e_rw  = dn ? mq[0].w : 1'b0;
                e_ack = dn && bus.result_ready_i;
                chk("rand", 64'({bus.instr_ready_o, bus.start_o, bus.result_valid_o,
                                 bus.result_id_o, bus.result_write_o, bus.lsu_finished_ack_o,
                                 bus.id_err_o, bus.instr_id_o, bus.address_o}),
                    64'({mq.size() < 2, e_st, e_rv, e_rid, e_rw, e_ack, merr, h_id, h_a}));
                issued  = infl || dn;
                popping = e_ack;
                pushing = bus.instr_valid_i && mq.size() < 2 && !fl;
                if (e_st) infl = 1;
                else if (infl && bus.lsu_finished_i) begin
                    if (bus.lsu_finished_id_i != mq[0].id) merr = 1;
                    infl = 0; dn = 1;
                end else if (popping) dn = 0;
                if (popping) void'(mq.pop_front());
                if (fl) begin
                    if (!issued || popping) mq.delete();
                    else while (mq.size() > 1) void'(mq.pop_back());
                end
                if (pushing) begin
                    ne.w = bus.instr_write_i; ne.id = bus.instr_id_i; ne.a = bus.instr_addr_i;
                    mq.push_back(ne);
                end
                nxt();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
